// File: rtl/mult8_shift_add_ctrl.sv
// mult8_shift_add_ctrl: sequential shift-and-add multiplier driving an external combinational adder.
// Define MULT8_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module mult8_shift_add_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [2*N-1:0] add_a,
  output logic [2*N-1:0] add_b,
  output logic           add_cin,
  input  logic [2*N-1:0] add_sum
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]     state_q, state_d;
  logic [2*N-1:0] acc_q, acc_d, mcand_q, mcand_d, product_q, product_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           early, last;
`ifdef MULT8_EARLY_TERM_EN
  assign early = (mplier_q[N-1:1] == '0);
`else
  assign early = 1'b0;
`endif
  assign last = (cnt_q == CW'(N - 1)) || early;
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (state_q == IDLE && start) begin
      acc_d    = '0;
      mcand_d  = {{N{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      state_d  = RUN;
    end else if (state_q == RUN) begin
      acc_d    = add_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      product_d = last ? add_sum : product_q;
      state_d   = last ? DONE : RUN;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign add_a   = acc_q;
  assign add_b   = (busy && mplier_q[0]) ? mcand_q : '0;
  assign add_cin = 1'b0;
endmodule

// File: tb/tb_mult8_shift_add_ctrl.sv
// tb_mult8_shift_add_ctrl: directed vectors with a product scoreboard popped on every done pulse.
module tb_mult8_shift_add_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done, add_cin;
  logic [15:0] product, add_a, add_b, add_sum;
  logic [15:0] exp_q[$];
  int          n_chk = 0, n_fail = 0;

  mult8_shift_add_ctrl #(.N(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum)
  );

  assign add_sum = add_a + add_b + {15'd0, add_cin};
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_k(input logic [7:0] bv);
`ifdef MULT8_EARLY_TERM_EN
    int h = 0;
    for (int i = 0; i < 8; i++) if (bv[i]) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    return 8;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'(product), 32'hFFFF_FFFF);
      else check("product", 32'(product), 32'(exp_q.pop_front()));
    end
  end

  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] p);
    logic [15:0] macc, mmc, eb;
    logic [7:0]  mpl;
    int j;
    @(negedge clk);
    start = 1'b1; a = ai; b = bi;
    exp_q.push_back(p);
    @(posedge clk);
    #1 start = 1'b0; a = 8'($urandom); b = 8'($urandom);
    macc = '0; mmc = {8'd0, ai}; mpl = bi; j = 0;
    @(negedge clk);
    check("busy_after_e0", 32'(busy), 32'd1);
    while (busy && j < 40) begin
      eb = mpl[0] ? mmc : 16'd0;
      check("add_a", 32'(add_a), 32'(macc));
      check("add_b", 32'(add_b), 32'(eb));
      macc = macc + eb; mmc = mmc << 1; mpl = mpl >> 1;
      @(negedge clk);
      j++;
    end
    check("latency", j, exp_k(bi));
    check("done_pulse", 32'(done), 32'd1);
    check("add_b_idle", 32'(add_b), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("product_hold", 32'(product), 32'(p));
  endtask

  task automatic wait_done(input string name);
    int j = 0;
    while (!done && j < 40) begin
      @(negedge clk);
      j++;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_cin", 32'(add_cin), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd13, 8'd11, 16'h008F);
    run_op(8'd255, 8'd255, 16'hFE01);
    run_op(8'hA5, 8'd0, 16'h0000);
    run_op(8'd200, 8'h04, 16'h0320);
    run_op(8'hFF, 8'd1, 16'h00FF);
    // start held high: re-acceptance only in the IDLE cycle after DONE
    @(negedge clk);
    start = 1'b1; a = 8'd3; b = 8'd5;
    exp_q.push_back(16'd15);
    exp_q.push_back(16'd15);
    @(negedge clk);
    check("held_busy", 32'(busy), 32'd1);
    wait_done("held_done1");
    @(negedge clk);
    check("held_idle_busy", 32'(busy), 32'd0);
    check("held_idle_done", 32'(done), 32'd0);
    @(negedge clk);
    check("held_reaccept", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done("held_done2");
    @(negedge clk);
    // reset in the middle of a run
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_add_a", 32'(add_a), 32'd0);
    check("midrst_add_b", 32'(add_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd7, 8'd9, 16'd63);
    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
